// File: rtl/tally_bcd_converter_if.sv
// Tally selection inputs and BCD display outputs of tally_bcd_converter.
// master = vote counter / display side, slave = converter.
interface tally_bcd_converter_if;
  logic       BJP_FIG;
  logic       CONG_FIG;
  logic       NOTA_FIG;
  logic [9:0] BJP_COUNT;
  logic [9:0] CONG_COUNT;
  logic [9:0] NOTA_COUNT;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic       busy;
  logic       update;

  modport master (
    output BJP_FIG, CONG_FIG, NOTA_FIG, BJP_COUNT, CONG_COUNT, NOTA_COUNT,
    input  ones, tens, hundreds, thousands, busy, update
  );

  modport slave (
    input  BJP_FIG, CONG_FIG, NOTA_FIG, BJP_COUNT, CONG_COUNT, NOTA_COUNT,
    output ones, tens, hundreds, thousands, busy, update
  );
endinterface

// File: rtl/tally_bcd_converter.sv
// Selects a vote tally and converts it to four BCD digits by double-dabble.
// Define TALLY_TOTAL_EN to show the sum of all tallies when no FIG is asserted.
module tally_bcd_converter (
  input  logic                  clk,
  input  logic                  reset,
  tally_bcd_converter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [11:0] operand;
  logic [11:0] src_q, src_d;
  logic [11:0] shreg_q, shreg_d;
  logic [11:0] last_q, last_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] digits_q, digits_d;
  logic        busy_q, busy_d;
  logic        upd_q, upd_d;
  logic [27:0] shifted;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    if (bus.BJP_FIG)       operand = {2'b00, bus.BJP_COUNT};
    else if (bus.CONG_FIG) operand = {2'b00, bus.CONG_COUNT};
    else if (bus.NOTA_FIG) operand = {2'b00, bus.NOTA_COUNT};
    else begin
`ifdef TALLY_TOTAL_EN
      operand = 12'(bus.BJP_COUNT) + 12'(bus.CONG_COUNT) + 12'(bus.NOTA_COUNT);
`else
      operand = '0;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    upd_d    = 1'b0;
    shifted  = {add3(bcd_q), shreg_q} << 1;
    case (state_q)
      IDLE: begin
        if (operand != last_q) begin
          src_d   = operand;
          shreg_d = operand;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = shifted;
        step_d = step_q + 4'd1;
        if (step_q == 4'd11) state_d = DONE;
      end
      DONE: begin
        // src_q keeps the pre-shift operand; shreg_q has been shifted out by now.
        digits_d = bcd_q;
        last_d   = src_q;
        upd_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      shreg_q  <= '0;
      last_q   <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.ones      = digits_q[3:0];
  assign bus.tens      = digits_q[7:4];
  assign bus.hundreds  = digits_q[11:8];
  assign bus.thousands = digits_q[15:12];
  assign bus.busy      = busy_q;
  assign bus.update    = upd_q;

endmodule
